// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM encoding and GF(2^8)/S-box helpers.
package aes_pkg;

   localparam int unsigned AES_BLOCK_W       = 128;
   localparam int unsigned NUM_ROUNDS_AES128 = 10;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRound = 2'd1,
      StDone  = 2'd2
   } aes_fsm_e;

   // Forward S-box, entry 0x00 in the most significant byte.
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Entry b sits at bit offset (255 - b) * 8, and 255 - b is simply ~b.
   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TABLE[{~b, 3'b000} +: 8];
   endfunction

   // Round constant for key expansion; rounds outside 1..10 yield zero.
   function automatic logic [7:0] rcon(input logic [3:0] rnd);
      logic [7:0] v;
      case (rnd)
         4'd1:    v = 8'h01;
         4'd2:    v = 8'h02;
         4'd3:    v = 8'h04;
         4'd4:    v = 8'h08;
         4'd5:    v = 8'h10;
         4'd6:    v = 8'h20;
         4'd7:    v = 8'h40;
         4'd8:    v = 8'h80;
         4'd9:    v = 8'h1b;
         4'd10:   v = 8'h36;
         default: v = 8'h00;
      endcase
      return v;
   endfunction

   // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

endpackage

// File: rtl/aes_round_dp.sv
// One AES encryption round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
// Purely combinational; byte 0 is the most significant byte of each bus.
module aes_round_dp
   import aes_pkg::*;
(
   input  logic [AES_BLOCK_W-1:0] i_state,
   input  logic [AES_BLOCK_W-1:0] i_round_key,
   input  logic                   i_last_round,
   output logic [AES_BLOCK_W-1:0] o_state
);

   logic [7:0] w_sb [16];
   logic [7:0] w_sr [16];
   logic [7:0] w_mc [16];

   // SubBytes: 16 parallel S-box lookups.
   for (genvar i = 0; i < 16; i++) begin : g_sub
      assign w_sb[i] = sbox(i_state[AES_BLOCK_W-1-8*i -: 8]);
   end

   // ShiftRows: byte index is row + 4*col; row r rotates left by r columns.
   for (genvar r = 0; r < 4; r++) begin : g_row
      for (genvar c = 0; c < 4; c++) begin : g_col
         assign w_sr[r+4*c] = w_sb[r+4*((c+r)%4)];
      end
   end

   // MixColumns on each column.
   for (genvar c = 0; c < 4; c++) begin : g_mix
      logic [7:0] w_a0, w_a1, w_a2, w_a3;
      assign w_a0 = w_sr[4*c];
      assign w_a1 = w_sr[4*c+1];
      assign w_a2 = w_sr[4*c+2];
      assign w_a3 = w_sr[4*c+3];
      assign w_mc[4*c]   = xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
      assign w_mc[4*c+1] = w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3;
      assign w_mc[4*c+2] = w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3;
      assign w_mc[4*c+3] = xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3);
   end

   // AddRoundKey; the final round skips MixColumns.
   for (genvar k = 0; k < 16; k++) begin : g_ark
      assign o_state[AES_BLOCK_W-1-8*k -: 8] = (i_last_round ? w_sr[k] : w_mc[k])
                                               ^ i_round_key[AES_BLOCK_W-1-8*k -: 8];
   end

endmodule

// File: rtl/aes128_iter_ctrl.sv
// Iterative AES-128 encryption controller: accepts a block and key, runs one
// shared round datapath for 10 cycles with on-the-fly key expansion, then
// holds the ciphertext until the consumer takes it.
module aes128_iter_ctrl #(
   parameter int unsigned NUM_ROUNDS = 10,
   parameter int unsigned RND_W      = 4
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [127:0]     i_block,
   input  logic [127:0]     i_key,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [127:0]     o_result,
   output logic             o_busy,
   output logic [RND_W-1:0] o_round
);

   import aes_pkg::*;

   if (NUM_ROUNDS != NUM_ROUNDS_AES128) begin : g_bad_rounds
      $error("aes128_iter_ctrl: NUM_ROUNDS must be 10");
   end
   if ((2 ** RND_W) <= NUM_ROUNDS) begin : g_bad_rnd_w
      $error("aes128_iter_ctrl: RND_W too narrow for NUM_ROUNDS");
   end

   localparam logic [RND_W-1:0] LAST_ROUND = RND_W'(NUM_ROUNDS);

   aes_fsm_e                r_fsm_q, w_fsm_d;
   logic [AES_BLOCK_W-1:0] r_state_q, w_state_d;
   logic [AES_BLOCK_W-1:0] r_rk_q, w_rk_d;
   logic [RND_W-1:0]       r_round_q, w_round_d;

   logic                   w_last_round;
   logic [7:0]             w_rcon;
   logic [31:0]            w_rot, w_sub, w_temp;
   logic [31:0]            w_n0, w_n1, w_n2, w_n3;
   logic [AES_BLOCK_W-1:0] w_rk_next;
   logic [AES_BLOCK_W-1:0] w_dp_state;

   // >= rather than == so a corrupted counter still terminates the block.
   assign w_last_round = (r_round_q >= LAST_ROUND);
   assign w_rcon       = rcon(r_round_q[3:0]);

   // Key schedule: RotWord, SubWord, rcon, then chained XOR across the words.
   assign w_rot     = {r_rk_q[23:0], r_rk_q[31:24]};
   assign w_sub     = {sbox(w_rot[31:24]), sbox(w_rot[23:16]),
                       sbox(w_rot[15:8]),  sbox(w_rot[7:0])};
   assign w_temp    = w_sub ^ {w_rcon, 24'h000000};
   assign w_n0      = r_rk_q[127:96] ^ w_temp;
   assign w_n1      = r_rk_q[95:64]  ^ w_n0;
   assign w_n2      = r_rk_q[63:32]  ^ w_n1;
   assign w_n3      = r_rk_q[31:0]   ^ w_n2;
   assign w_rk_next = {w_n0, w_n1, w_n2, w_n3};

   aes_round_dp u_round_dp (
      .i_state      (r_state_q),
      .i_round_key  (w_rk_next),
      .i_last_round (w_last_round),
      .o_state      (w_dp_state)
   );

   assign o_result = r_state_q;
   assign o_round  = r_round_q;

   // Next-state and handshake outputs.
   always_comb begin
      w_fsm_d     = r_fsm_q;
      w_state_d   = r_state_q;
      w_rk_d      = r_rk_q;
      w_round_d   = r_round_q;
      o_in_ready  = 1'b0;
      o_out_valid = 1'b0;
      o_busy      = 1'b0;
      case (r_fsm_q)
         StIdle: begin
            o_in_ready = 1'b1;
            if (i_in_valid) begin
               w_state_d = i_block ^ i_key;
               w_rk_d    = i_key;
               w_round_d = RND_W'(1);
               w_fsm_d   = StRound;
            end
         end
         StRound: begin
            o_busy    = 1'b1;
            w_state_d = w_dp_state;
            w_rk_d    = w_rk_next;
            if (w_last_round) begin
               w_round_d = '0;
               w_fsm_d   = StDone;
            end else begin
               w_round_d = r_round_q + RND_W'(1);
            end
         end
         StDone: begin
            o_out_valid = 1'b1;
            if (i_out_ready) begin
               w_fsm_d = StIdle;
            end
         end
         default: begin
            w_fsm_d   = StIdle;
            w_round_d = '0;
         end
      endcase
   end

   // State registers with synchronous reset taking priority over handshakes.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_fsm_q   <= StIdle;
         r_state_q <= '0;
         r_rk_q    <= '0;
         r_round_q <= '0;
      end else begin
         r_fsm_q   <= w_fsm_d;
         r_state_q <= w_state_d;
         r_rk_q    <= w_rk_d;
         r_round_q <= w_round_d;
      end
   end

endmodule

// File: tb/tb_aes128_iter_ctrl.sv
// Directed bench for aes128_iter_ctrl using FIPS-197 vectors.
module tb_aes128_iter_ctrl;

   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] blk;
   logic [127:0] key;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] result;
   logic         busy;
   logic [3:0]   round;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   aes128_iter_ctrl #(
      .NUM_ROUNDS (10),
      .RND_W      (4)
   ) dut (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_in_valid  (in_valid),
      .o_in_ready  (in_ready),
      .i_block     (blk),
      .i_key       (key),
      .o_out_valid (out_valid),
      .i_out_ready (out_ready),
      .o_result    (result),
      .o_busy      (busy),
      .o_round     (round)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Present one block at a negedge; returns at the negedge after the accept edge.
   task automatic send(input logic [127:0] pt, input logic [127:0] k);
      chk("in_ready_before_send", 128'(in_ready), 128'd1);
      in_valid = 1'b1;
      blk      = pt;
      key      = k;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Count negedges until out_valid, optionally scrambling the inputs each cycle.
   task automatic wait_out(input int start, input bit scramble, output int lat);
      lat = start;
      do begin
         if (scramble) begin
            blk = {$urandom, $urandom, $urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom};
         end
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 30);
   endtask

   int           lat;
   int           n;
   bit           stable;
   bit           ov_seen;
   int           acc;
   int           nres;
   int           acc_cyc [4];
   logic [127:0] res [4];
   bit           accept_now;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      blk       = '0;
      key       = '0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("rst_in_ready", 128'(in_ready), 128'd1);
      chk("rst_out_valid", 128'(out_valid), 128'd0);
      chk("rst_busy", 128'(busy), 128'd0);
      chk("rst_round", 128'(round), 128'd0);
      chk("rst_result", result, 128'd0);

      // C.1 with out_ready already high before out_valid.
      out_ready = 1'b1;
      send(C1_PT, C1_KEY);
      chk("c1_round1", 128'(round), 128'd1);
      chk("c1_busy", 128'(busy), 128'd1);
      chk("c1_in_ready_low", 128'(in_ready), 128'd0);
      wait_out(0, 1'b0, lat);
      chk("c1_latency", 128'(lat), 128'd10);
      chk("c1_result", result, C1_CT);
      chk("c1_round_done", 128'(round), 128'd0);
      @(negedge clk);
      chk("c1_out_valid_clr", 128'(out_valid), 128'd0);
      chk("c1_in_ready_back", 128'(in_ready), 128'd1);

      // Appendix B, including the first expanded round key.
      send(B_PT, B_KEY);
      chk("b_rk0", dut.r_rk_q, B_KEY);
      @(negedge clk);
      chk("b_rk1", dut.r_rk_q, B_RK1);
      wait_out(1, 1'b0, lat);
      chk("b_latency", 128'(lat), 128'd10);
      chk("b_result", result, B_CT);
      @(negedge clk);

      // Backpressure: hold the result for 20 cycles.
      out_ready = 1'b0;
      send(C1_PT, C1_KEY);
      wait_out(0, 1'b0, lat);
      chk("bp_latency", 128'(lat), 128'd10);
      stable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b1 || result !== C1_CT || in_ready !== 1'b0 || busy !== 1'b0)
            stable = 1'b0;
      end
      chk("bp_stable", 128'(stable), 128'd1);
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_out_valid_clr", 128'(out_valid), 128'd0);
      chk("bp_in_ready", 128'(in_ready), 128'd1);

      // Inputs change every cycle after the accept.
      send(C1_PT, C1_KEY);
      wait_out(0, 1'b1, lat);
      chk("stab_result", result, C1_CT);
      blk = '0;
      key = '0;
      @(negedge clk);

      // Reset at round 5 discards the block.
      send(B_PT, B_KEY);
      n = 0;
      while (round !== 4'd5 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("mid_round5", 128'(round), 128'd5);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("mid_in_ready", 128'(in_ready), 128'd1);
      chk("mid_busy", 128'(busy), 128'd0);
      chk("mid_round0", 128'(round), 128'd0);
      chk("mid_result0", result, 128'd0);
      ov_seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
         if (out_valid !== 1'b0) ov_seen = 1'b1;
         @(negedge clk);
      end
      chk("mid_no_out_valid", 128'(ov_seen), 128'd0);
      send(B_PT, B_KEY);
      wait_out(0, 1'b0, lat);
      chk("mid_b_result", result, B_CT);
      @(negedge clk);

      // Streaming with in_valid held high: B then C.1.
      in_valid = 1'b1;
      blk      = B_PT;
      key      = B_KEY;
      acc      = 0;
      nres     = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         accept_now = in_ready && in_valid;
         if (out_valid && out_ready) begin
            if (nres < 4) res[nres] = result;
            nres++;
         end
         @(negedge clk);
         if (accept_now) begin
            if (acc < 4) acc_cyc[acc] = cyc;
            acc++;
            if (acc == 1) begin
               blk = C1_PT;
               key = C1_KEY;
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      chk("str_accepts", 128'(acc), 128'd2);
      if (acc >= 2) chk("str_gap", 128'(acc_cyc[1] - acc_cyc[0]), 128'd12);
      chk("str_results", 128'(nres), 128'd2);
      if (nres >= 1) chk("str_res0", res[0], B_CT);
      if (nres >= 2) chk("str_res1", res[1], C1_CT);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/aes128_iter_ctrl.md
Name: aes128_iter_ctrl

Overview:
- Iterative AES-128 encryption controller that sequences one shared round datapath over 10 rounds per block.
- Captures a 128-bit plaintext block and cipher key through a valid/ready handshake.
- Generates round keys on the fly, one per cycle, and holds the ciphertext until the consumer accepts it.
- Sits between the host/bus interface and the combinational AES primitives (SubBytes, ShiftRows, MixColumns, AddRoundKey), replacing their single-shot combinational use.

Parameters:
- NUM_ROUNDS, 10, number of cipher rounds. Only 10 (AES-128) is legal; any other value is flagged by an elaboration-time check.
- RND_W, 4, width of the round counter; must satisfy 2**RND_W > NUM_ROUNDS.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  block and key present
- in_ready  out  1  controller can accept a block
- block  in  128  plaintext; block[127:120] is byte 0 (FIPS-197 order)
- key  in  128  cipher key, same byte order
- out_valid  out  1  result holds valid ciphertext
- out_ready  in  1  consumer accepts result
- result  out  128  ciphertext, same byte order
- busy  out  1  high in ROUND state
- round  out  RND_W  current round index, for debug

Behaviour:
- FSM states: IDLE, ROUND, DONE.
- Reset values:
  - FSM = IDLE; in_ready = 1; out_valid = 0; busy = 0.
  - round = 0; result = 0; internal state and round-key registers = 0.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid=1:
    - state_reg <= block ^ key
    - rk_reg <= key
    - round <= 1
    - FSM -> ROUND
  - block and key are sampled only at this edge; later changes are ignored.
- ROUND (in_ready = 0, busy = 1), on each edge:
  - rk_next = expand(rk_reg, rcon[round]).
  - expand: RotWord, SubWord, XOR with rcon, then a chained XOR across the 4 words.
  - rcon[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
  - Rounds 1-9: state_reg <= MixColumns(ShiftRows(SubBytes(state_reg))) ^ rk_next.
  - Round 10: MixColumns is bypassed.
  - rk_reg <= rk_next; round <= round + 1.
  - After the round-10 edge: FSM -> DONE, round <= 0.
- Latency:
  - out_valid rises exactly 10 edges after the accepting edge.
  - Minimum period is 12 cycles per block: accept, 10 rounds, 1 handshake.
- DONE:
  - out_valid = 1; result = state_reg, held stable while out_ready = 0 (unbounded backpressure).
  - On an edge with out_ready=1: out_valid <= 0, FSM -> IDLE.
  - in_ready stays 0 in DONE. There is no same-cycle turnaround; the next accept occurs at the earliest one edge later.
- Boundary conditions:
  - in_valid held high continuously: blocks are accepted back-to-back at the 12-cycle cadence, with no duplicate or lost accept.
  - out_ready high before out_valid: no effect.
  - Reset asserted in any state, including mid-ROUND: at that edge return to reset values, and the partial computation is discarded with no out_valid pulse. Reset has priority over every handshake in the same cycle.
  - Round counter never exceeds NUM_ROUNDS; an illegal FSM encoding recovers to IDLE.
- Only one S-box instance set is shared per function: 16 lookups for state bytes and 4 for key expansion, both combinational in the same cycle.

Decomposition:
- Package aes_pkg:
  - S-box table function sbox(byte)
  - rcon table function
  - xtime / gf_mul2 function
  - FSM state enum {IDLE, ROUND, DONE}
  - AES_BLOCK_W = 128 constant
  - NUM_ROUNDS_AES128 = 10 constant
- Sub-module aes_round_dp:
  - Purely combinational.
  - Inputs: state, round key, last_round flag. Output: next state.
  - Implements SubBytes, ShiftRows, conditional MixColumns and AddRoundKey.
- Key expansion stays inline in the controller (one word chain plus rcon).

Test Plan:
- FIPS-197 C.1: block=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f, out_ready=1 -> out_valid exactly 10 edges after accept, result=69c4e0d86a7b0430d8cdb78070b4c55a.
- FIPS-197 App. B: block=3243f6a8885a308d313198a2e0370734, key=2b7e151628aed2a6abf7158809cf4f3c -> after round 1, internal rk=a0fafe1788542cb123a339392a6c7605; result=3925841d02dc09fbdc118597196a0b32.
- Backpressure: run C.1 with out_ready=0 for 20 cycles after out_valid -> result and out_valid stable, in_ready=0 throughout; out_ready=1 -> one-cycle handshake, then in_ready=1 on the next cycle.
- Input stability: change block and key on every cycle after the accept -> result is still 69c4e0d86a7b0430d8cdb78070b4c55a for the originally sampled C.1 vectors.
- Reset mid-operation: assert reset for 1 cycle at round=5 -> next cycle FSM=IDLE, in_ready=1, out_valid never pulses; a following App. B block still yields 3925841d02dc09fbdc118597196a0b32.
- Streaming: in_valid held high with B, then C.1 -> accepts 12 cycles apart, results in order 3925841d…, then 69c4e0d8…, with no extra accept.
